// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage (CPU) and the
// external loader/debug port (EXT), stalls the CPU while its access is pending.
module dmem_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_stall_o,
  input  logic             ext_req_i,
  input  logic             ext_we_i,
  input  logic [31:0]      ext_addr_i,
  input  logic [31:0]      ext_wdata_i,
  output logic [31:0]      ext_rdata_o,
  output logic             ext_ack_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int            WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [3:0]    LAT      = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;  // 1 = EXT owns the current access
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      ext_rdata_q, ext_rdata_d;
  logic [3:0]       lat_q, lat_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             ext_win;

  assign cpu_stall_o = cpu_req_i & ~((state_q == RESP) & ~owner_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    lat_d       = lat_q;
    wait_d      = wait_q;
    stall_cnt_d = stall_cnt_q;
    ext_win     = ext_req_i & (~cpu_req_i | (wait_q >= WAIT_MAX));

    // EXT ages only while it is not the one being served
    if (ext_req_i && !(owner_q && state_q != IDLE) && wait_q < WAIT_MAX)
      wait_d = wait_q + 1'b1;

    if (cpu_stall_o && start_i && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i && (cpu_req_i || ext_req_i)) begin
          state_d = BUSY;
          owner_d = ext_win;
          lat_d   = LAT;
          if (ext_win) begin
            we_d    = ext_we_i;
            addr_d  = ext_addr_i & ~32'h3;
            wdata_d = ext_wdata_i;
            wait_d  = '0;
          end else begin
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i & ~32'h3;
            wdata_d = cpu_wdata_i;
          end
        end
      end
      BUSY: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          state_d = RESP;
          if (owner_q) ext_rdata_d = mem_rdata_i;
          else         cpu_rdata_d = mem_rdata_i;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      lat_q       <= '0;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      lat_q       <= lat_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The strobe fires only while the counter still holds its load value
  assign mem_en_o    = (state_q == BUSY) && (lat_q == LAT);
  assign mem_we_o    = (state_q == BUSY) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ext_ack_o   = (state_q == RESP) && owner_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign ext_rdata_o = ext_rdata_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// its own latency-accurate memory model; responses are checked via a scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  bit          sel3;

  logic        cpu_req1, cpu_req3, ext_req1, ext_req3;
  logic [31:0] c1_rd, c3_rd, e1_rd, e3_rd, m1_addr, m3_addr, m1_wd, m3_wd, m1_rd, m3_rd;
  logic        c1_stall, c3_stall, e1_ack, e3_ack, m1_en, m3_en, m1_we, m3_we;
  logic [31:0] s1_cnt, s3_cnt;

  logic [31:0] v_crd, v_erd, v_addr, v_wd, v_scnt;
  logic        v_stall, v_ack, v_en, v_we;

  always #5 clk = ~clk;

  assign cpu_req1 = cpu_req & ~sel3;
  assign cpu_req3 = cpu_req & sel3;
  assign ext_req1 = ext_req & ~sel3;
  assign ext_req3 = ext_req & sel3;

  dmem_arbiter #(.MEM_LAT(1), .MAX_WAIT(4), .CNT_W(32)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(cpu_req1), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(c1_rd), .cpu_stall_o(c1_stall),
    .ext_req_i(ext_req1), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rdata_o(e1_rd), .ext_ack_o(e1_ack),
    .mem_en_o(m1_en), .mem_we_o(m1_we), .mem_addr_o(m1_addr), .mem_wdata_o(m1_wd),
    .mem_rdata_i(m1_rd), .stall_cnt_o(s1_cnt));

  dmem_arbiter #(.MEM_LAT(3), .MAX_WAIT(4), .CNT_W(32)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .cpu_req_i(cpu_req3), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(c3_rd), .cpu_stall_o(c3_stall),
    .ext_req_i(ext_req3), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rdata_o(e3_rd), .ext_ack_o(e3_ack),
    .mem_en_o(m3_en), .mem_we_o(m3_we), .mem_addr_o(m3_addr), .mem_wdata_o(m3_wd),
    .mem_rdata_i(m3_rd), .stall_cnt_o(s3_cnt));

  assign v_crd   = sel3 ? c3_rd    : c1_rd;
  assign v_erd   = sel3 ? e3_rd    : e1_rd;
  assign v_stall = sel3 ? c3_stall : c1_stall;
  assign v_ack   = sel3 ? e3_ack   : e1_ack;
  assign v_en    = sel3 ? m3_en    : m1_en;
  assign v_we    = sel3 ? m3_we    : m1_we;
  assign v_addr  = sel3 ? m3_addr  : m1_addr;
  assign v_wd    = sel3 ? m3_wd    : m1_wd;
  assign v_scnt  = sel3 ? s3_cnt   : s1_cnt;

  // Memory models: read data is only valid in the cycle the arbiter samples it
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  int since1 = 0;
  int since3 = 0;

  always @(posedge clk) begin
    if (m1_en) begin
      since1 <= 1;
      if (m1_we) mem1[m1_addr[7:2]] <= m1_wd;
    end else if (since1 != 0 && since1 < 16) since1 <= since1 + 1;
    else since1 <= 0;
    if (m3_en) begin
      since3 <= 1;
      if (m3_we) mem3[m3_addr[7:2]] <= m3_wd;
    end else if (since3 != 0 && since3 < 16) since3 <= since3 + 1;
    else since3 <= 0;
  end

  assign m1_rd = m1_en ? mem1[m1_addr[7:2]] : 32'hDEAD_BEEF;
  assign m3_rd = (since3 == 2) ? mem3[m3_addr[7:2]] : 32'hDEAD_BEEF;

  typedef struct {
    bit          ext;
    bit          chk;
    logic [31:0] rd;
  } sb_t;

  typedef struct {
    bit          sel3;
    bit          ext;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] scnt;
  } vec_t;

  sb_t  sb [$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  int   we_cyc = 0;
  int   ack_cnt = 0;
  int   resp_cnt = 0;
  logic [31:0] en_addr = '0;
  logic [31:0] en_wd = '0;
  logic        en_we = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic sb_pop(input bit ext, input logic [31:0] rd);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp: got port %0d with no pending request", ext);
    end else begin
      e = sb.pop_front();
      chk("resp_port", 32'(ext), 32'(e.ext));
      if (e.chk) chk("resp_data", rd, e.rd);
    end
    resp_cnt++;
  endtask

  always @(negedge clk) begin
    if (v_en) begin
      en_cnt++;
      en_addr = v_addr;
      en_we   = v_we;
      en_wd   = v_wd;
    end
    if (v_we) we_cyc++;
    if (v_ack) ack_cnt++;
    if (!rst) begin
      if (cpu_req && !v_stall) sb_pop(1'b0, v_crd);
      if (v_ack) sb_pop(1'b1, v_erd);
    end
  end

  task automatic do_acc(input vec_t v);
    int n, e0, w0, lat;
    lat  = v.sel3 ? 3 : 1;
    sel3 = v.sel3;
    e0   = en_cnt;
    w0   = we_cyc;
    sb.push_back('{v.ext, !v.we, v.rd});
    if (v.ext) begin
      ext_we = v.we; ext_addr = v.addr; ext_wdata = v.wd; ext_req = 1'b1;
    end else begin
      cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wd; cpu_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(v.ext ? v_ack : !v_stall) && n < 40);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    ext_req = 1'b0;
    chk("latency", 32'(n), 32'(lat + 2));
    chk("en_pulses", 32'(en_cnt - e0), 32'd1);
    chk("we_cycles", 32'(we_cyc - w0), v.we ? 32'(lat) : 32'd0);
    chk("en_addr", en_addr, {v.addr[31:2], 2'b00});
    chk("en_we", 32'(en_we), 32'(v.we));
    if (v.we) chk("en_wdata", en_wd, v.wd);
    chk("stall_cnt", v_scnt, v.scnt);
    if (n >= 40) sb.delete();
  endtask

  vec_t vt [8];

  initial begin
    int n, k, e0, a0, r0, st_n;
    vt[0] = '{1'b0, 1'b1, 1'b1, 32'h00, 32'h5,         32'h0,         32'd0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         32'h5,         32'd2};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h00, 32'h0,         32'h5,         32'd2};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'h13, 32'hA5A5_0001, 32'h0,         32'd4};
    vt[4] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,         32'hA5A5_0001, 32'd6};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'h04, 32'h8,         32'h0,         32'd4};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'h04, 32'h0,         32'h8,         32'd8};
    vt[7] = '{1'b1, 1'b1, 1'b0, 32'h06, 32'h0,         32'h8,         32'd8};

    rst = 1'b1; start = 1'b0; sel3 = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel3 = (s == 1);
      #1;
      chk("rst_en", 32'(v_en), 32'd0);
      chk("rst_we", 32'(v_we), 32'd0);
      chk("rst_addr", v_addr, 32'h0);
      chk("rst_ack", 32'(v_ack), 32'd0);
      chk("rst_scnt", v_scnt, 32'h0);
      chk("rst_crd", v_crd, 32'h0);
    end
    start = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_acc(vt[i]);

    // start_i low: CPU stays stalled, nothing is granted, nothing counted
    sel3 = 1'b0; start = 1'b0; e0 = en_cnt; st_n = 0;
    sb.push_back('{1'b0, 1'b1, 32'h5});
    cpu_we = 1'b0; cpu_addr = 32'h0; cpu_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (v_stall) st_n++;
    end
    chk("start0_stall", 32'(st_n), 32'd4);
    chk("start0_en", 32'(en_cnt - e0), 32'd0);
    chk("start0_scnt", v_scnt, 32'd6);
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (v_stall && n < 40);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("start1_latency", 32'(n), 32'd3);
    chk("start1_scnt", v_scnt, 32'd8);

    // Both held: CPU twice, then EXT once it has waited MAX_WAIT cycles; repeats
    r0 = resp_cnt;
    sb.push_back('{1'b0, 1'b1, 32'h5});
    sb.push_back('{1'b0, 1'b1, 32'h5});
    sb.push_back('{1'b1, 1'b1, 32'h5});
    sb.push_back('{1'b0, 1'b1, 32'h5});
    sb.push_back('{1'b0, 1'b1, 32'h5});
    sb.push_back('{1'b1, 1'b1, 32'h5});
    cpu_we = 1'b0; cpu_addr = 32'h0; ext_we = 1'b0; ext_addr = 32'h0;
    cpu_req = 1'b1; ext_req = 1'b1;
    k = 0;
    while (resp_cnt - r0 < 6 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    chk("arb_events", 32'(resp_cnt - r0), 32'd6);
    chk("arb_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;

    // CPU flush mid-BUSY: access completes silently, one strobe only
    sel3 = 1'b1; e0 = en_cnt;
    cpu_we = 1'b0; cpu_addr = 32'h4; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(v_stall), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("flush_en", 32'(en_cnt - e0), 32'd1);
    chk("flush_scnt", v_scnt, 32'd10);
    do_acc('{1'b1, 1'b0, 1'b0, 32'h04, 32'h0, 32'h8, 32'd14});

    // Reset in the middle of an EXT write
    a0 = ack_cnt;
    ext_we = 1'b1; ext_addr = 32'h8; ext_wdata = 32'h77; ext_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_we", 32'(v_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_en", 32'(v_en), 32'd0);
    chk("mrst_we", 32'(v_we), 32'd0);
    chk("mrst_addr", v_addr, 32'h0);
    chk("mrst_wdata", v_wd, 32'h0);
    chk("mrst_ack", 32'(v_ack), 32'd0);
    chk("mrst_scnt", v_scnt, 32'h0);
    chk("mrst_erd", v_erd, 32'h0);
    ext_req = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    e0 = en_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("mrst_no_en", 32'(en_cnt - e0), 32'd0);
    do_acc('{1'b1, 1'b0, 1'b0, 32'h04, 32'h0, 32'h8, 32'd4});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
